vram_arb: RTL and testbench

VRAM_ARB -- requirements
Module: vram_arb

---
 rtl/vram_arb.sv | 157 +++++++++++++++
 tb/tb_vram_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: display scan-out reads, one-entry host write hold
// register and a full-frame clear engine share one synchronous RAM port.
module vram_arb #(
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 1,
   parameter int unsigned PIX_TOTAL = 307200
) (
   input  logic              VGA_CLK,
   input  logic              RST,
   input  logic              DISP_RD,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   output logic [DATA_W-1:0] DISP_DATA,
   output logic              DISP_VALID,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              CLR_START,
   input  logic [DATA_W-1:0] CLR_DATA,
   output logic              CLR_BUSY,
   output logic              ADDR_ERR,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);

   typedef enum logic [1:0] {IDLE, PEND, CLEAR} clr_state_e;

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] fill_q, fill_d;

   logic              hold_full_q, hold_full_d;
   logic [ADDR_W-1:0] hold_addr_q;
   logic [DATA_W-1:0] hold_data_q;

   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              rd1_q, rd2_q, disp_valid_q;
   logic [DATA_W-1:0] disp_data_q;
   logic              wr_ready_q, wr_ready_d;
   logic              clr_busy_q, addr_err_q;

   logic              accept, hold_ld, drain, clr_wr;

   always_comb begin
      accept      = WR_VALID && wr_ready_q;
      hold_ld     = accept && (WR_ADDR <= LAST_ADDR);
      drain       = hold_full_q && !DISP_RD;
      clr_wr      = (state_q == CLEAR) && !DISP_RD && !hold_full_q;
      hold_full_d = hold_ld || (hold_full_q && !drain);

      state_d = state_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      case (state_q)
         IDLE: begin
            if (CLR_START) begin
               fill_d  = CLR_DATA;
               cnt_d   = '0;
               // a write accepted on this same edge must reach memory before the clear
               state_d = hold_full_d ? PEND : CLEAR;
            end
         end
         PEND: begin
            if (!hold_full_d) state_d = CLEAR;
         end
         CLEAR: begin
            if (clr_wr) begin
               if (cnt_q == LAST_ADDR) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      mem_en_d    = DISP_RD || drain || clr_wr;
      mem_we_d    = !DISP_RD && (drain || clr_wr);
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (DISP_RD) begin
         mem_addr_d = DISP_ADDR;
      end else if (drain) begin
         mem_addr_d  = hold_addr_q;
         mem_wdata_d = hold_data_q;
      end else if (clr_wr) begin
         mem_addr_d  = cnt_q;
         mem_wdata_d = fill_q;
      end

      // ready re-opens one edge after the hold register has actually emptied
      wr_ready_d = !hold_full_q && !accept && (state_d == IDLE);
   end

   always_ff @(posedge VGA_CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fill_q       <= '0;
         hold_full_q  <= 1'b0;
         hold_addr_q  <= '0;
         hold_data_q  <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rd1_q        <= 1'b0;
         rd2_q        <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
         wr_ready_q   <= 1'b0;
         clr_busy_q   <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_q       <= fill_d;
         hold_full_q  <= hold_full_d;
         if (hold_ld) begin
            hold_addr_q <= WR_ADDR;
            hold_data_q <= WR_DATA;
         end
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rd1_q        <= DISP_RD;
         rd2_q        <= rd1_q;
         disp_valid_q <= rd2_q;
         if (rd2_q) disp_data_q <= MEM_RDATA;
         wr_ready_q   <= wr_ready_d;
         clr_busy_q   <= (state_d != IDLE);
         if (accept && (WR_ADDR > LAST_ADDR)) addr_err_q <= 1'b1;
      end
   end

   assign MEM_EN     = mem_en_q;
   assign MEM_WE     = mem_we_q;
   assign MEM_ADDR   = mem_addr_q;
   assign MEM_WDATA  = mem_wdata_q;
   assign DISP_VALID = disp_valid_q;
   assign DISP_DATA  = disp_data_q;
   assign WR_READY   = wr_ready_q;
   assign CLR_BUSY   = clr_busy_q;
   assign ADDR_ERR   = addr_err_q;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: sync RAM model, transaction-level reference model with
// per-cycle output comparison, and directed scenarios with literal checks.
module tb_vram_arb;

   localparam int AW  = 10;
   localparam int DW  = 4;
   localparam int PIX = 300;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          disp_rd, wr_valid, clr_start;
   logic [AW-1:0] disp_addr, wr_addr;
   logic [DW-1:0] wr_data, clr_data;
   logic [DW-1:0] DISP_DATA, MEM_WDATA, MEM_RDATA;
   logic          DISP_VALID, WR_READY, CLR_BUSY, ADDR_ERR, MEM_EN, MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [23:0]   outs;

   vram_arb #(.ADDR_W(AW), .DATA_W(DW), .PIX_TOTAL(PIX)) dut (
      .VGA_CLK(clk), .RST(rst_n),
      .DISP_RD(disp_rd), .DISP_ADDR(disp_addr), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
      .WR_VALID(wr_valid), .WR_READY(WR_READY), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .CLR_START(clr_start), .CLR_DATA(clr_data), .CLR_BUSY(CLR_BUSY), .ADDR_ERR(ADDR_ERR),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA)
   );

   always #5 clk = ~clk;

   assign outs = {MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, DISP_VALID, DISP_DATA,
                  WR_READY, CLR_BUSY, ADDR_ERR};

   logic [DW-1:0] ram [0:1023];
   always @(posedge clk) begin
      if (MEM_EN) begin
         if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
         else        MEM_RDATA <= ram[MEM_ADDR];
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct packed { logic v; logic [DW-1:0] d; } rd_t;

   wr_t           hold_q[$];
   rd_t           rpipe[$];
   logic [DW-1:0] img [0:1023];
   bit            m_en, m_we, m_valid, m_ready, m_busy, m_pend, m_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_data, m_fill;
   int unsigned   m_next;
   bit            pw_v;
   logic [AW-1:0] pw_a;
   logic [DW-1:0] pw_d;

   task automatic model_reset();
      hold_q.delete(); rpipe.delete();
      m_en = 0; m_we = 0; m_valid = 0; m_ready = 0; m_busy = 0; m_pend = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_data = '0; m_fill = '0; m_next = 0; pw_v = 0;
   endtask

   task automatic model_step();
      wr_t e;
      rd_t r;
      bit  acc, pend_pre, busy_pre, hold_empty_pre;
      // a write granted last edge lands in RAM on this edge
      if (pw_v) img[pw_a] = pw_d;
      pw_v = 0;
      acc = wr_valid && m_ready;
      pend_pre = m_pend; busy_pre = m_busy; hold_empty_pre = (hold_q.size() == 0);
      m_en = 0; m_we = 0; r = '0;
      if (disp_rd) begin
         m_en = 1; m_addr = disp_addr; r.v = 1; r.d = img[disp_addr];
      end else if (!hold_empty_pre) begin
         e = hold_q.pop_front();
         m_en = 1; m_we = 1; m_addr = e.a; m_wdata = e.d;
      end else if (busy_pre && !pend_pre) begin
         m_en = 1; m_we = 1; m_addr = AW'(m_next); m_wdata = m_fill;
         m_next++;
         if (m_next == PIX) begin m_busy = 0; m_next = 0; end
      end
      if (m_we) begin pw_v = 1; pw_a = m_addr; pw_d = m_wdata; end
      if (acc) begin
         if (wr_addr >= PIX) m_err = 1;
         else begin e.a = wr_addr; e.d = wr_data; hold_q.push_back(e); end
      end
      if (pend_pre && hold_q.size() == 0) m_pend = 0;
      if (!busy_pre && clr_start) begin
         m_busy = 1; m_fill = clr_data; m_next = 0; m_pend = (hold_q.size() != 0);
      end
      m_ready = hold_empty_pre && !acc && !m_busy;
      rpipe.push_back(r);
      m_valid = 0;
      if (rpipe.size() == 3) begin
         r = rpipe.pop_front();
         m_valid = r.v;
         if (r.v) m_data = r.d;
      end
   endtask

   // monitor data gathered from the DUT for the directed literal checks
   int            we_cnt = 0;
   int            wr_hits [0:1023];
   logic [AW-1:0] wr_log[$];
   logic [AW-1:0] last_we_addr;
   logic [DW-1:0] got_q[$];

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      check("cycle", 64'(outs),
            64'({m_en, m_we, m_addr, m_wdata, m_valid, m_data, m_ready, m_busy, m_err}));
      if (MEM_EN && MEM_WE) begin
         we_cnt++;
         wr_hits[MEM_ADDR]++;
         wr_log.push_back(MEM_ADDR);
         last_we_addr = MEM_ADDR;
      end
      if (DISP_VALID) got_q.push_back(DISP_DATA);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_clear(input logic [DW-1:0] d, input bit toggle, input string nm);
      int base, bad;
      bit tmo;
      foreach (wr_hits[i]) wr_hits[i] = 0;
      base = we_cnt;
      clr_start = 1; clr_data = d;
      @(negedge clk);
      clr_start = 0;
      tmo = 1;
      for (int i = 0; i < 3000; i++) begin
         if (toggle) begin disp_rd = ~disp_rd; disp_addr = AW'(i % PIX); end
         @(negedge clk);
         if (!CLR_BUSY) begin tmo = 0; break; end
      end
      disp_rd = 0;
      cyc(3);
      check({nm, "_timeout"}, 64'(tmo), 64'd0);
      check({nm, "_write_count"}, 64'(we_cnt - base), 64'(PIX));
      bad = 0;
      for (int a = 0; a < 1024; a++) if (wr_hits[a] != ((a < PIX) ? 1 : 0)) bad++;
      check({nm, "_bad_addresses"}, 64'(bad), 64'd0);
   endtask

   initial begin
      int  base, rdy_hi;
      bit  tmo, found;
      for (int i = 0; i < 1024; i++) begin
         ram[i] = DW'((i * 3 + 1) % 16);
         img[i] = DW'((i * 3 + 1) % 16);
         wr_hits[i] = 0;
      end
      rst_n = 0; disp_rd = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
      clr_start = 0; clr_data = '0;

      #1 check("reset_outputs", 64'(outs), 64'd0);
      cyc(3);
      rst_n = 1;
      @(posedge clk); #2;
      check("ready_after_reset", 64'(WR_READY), 64'd1);

      // continuous scan-out reads
      @(negedge clk);
      got_q.delete();
      for (int i = 0; i < 20; i++) begin
         disp_rd = 1; disp_addr = AW'(i);
         @(negedge clk);
      end
      disp_rd = 0;
      cyc(4);
      check("scan_valid_count", 64'(got_q.size()), 64'd20);
      check("scan_data_addr0", 64'(got_q[0]), 64'd1);
      check("scan_data_addr7", 64'(got_q[7]), 64'd6);

      // host write waits behind 5 display reads
      base = we_cnt; rdy_hi = 0;
      wr_valid = 1; wr_addr = 10'd100; wr_data = 4'd1; disp_rd = 1; disp_addr = 10'd5;
      @(negedge clk);
      wr_valid = 0;
      if (WR_READY) rdy_hi++;
      repeat (4) begin @(negedge clk); if (WR_READY) rdy_hi++; end
      disp_rd = 0;
      @(negedge clk);
      if (WR_READY) rdy_hi++;
      @(negedge clk);
      check("hold_ready_back", 64'(WR_READY), 64'd1);
      cyc(3);
      check("hold_we_once", 64'(we_cnt - base), 64'd1);
      check("hold_we_addr", 64'(last_we_addr), 64'd100);
      check("hold_ready_low", 64'(rdy_hi), 64'd0);

      // out-of-range write is dropped and flagged
      base = we_cnt;
      wr_valid = 1; wr_addr = 10'd300; wr_data = 4'd5;
      @(negedge clk);
      wr_valid = 0;
      cyc(5);
      check("oor_no_we", 64'(we_cnt - base), 64'd0);
      check("oor_addr_err", 64'(ADDR_ERR), 64'd1);

      // full clear, display idle, then read back
      run_clear(4'hA, 1'b0, "clr_idle");
      check("addr_err_sticky", 64'(ADDR_ERR), 64'd1);
      got_q.delete();
      disp_rd = 1; disp_addr = 10'd0;   @(negedge clk);
      disp_addr = 10'd150;              @(negedge clk);
      disp_addr = 10'd299;              @(negedge clk);
      disp_rd = 0;
      cyc(4);
      check("clr_readback_299", 64'(got_q[2]), 64'hA);

      // full clear with display reads every other edge
      run_clear(4'h3, 1'b1, "clr_toggle");

      // clear requested while the hold register is full
      wr_log.delete(); rdy_hi = 0;
      wr_valid = 1; wr_addr = 10'd50; wr_data = 4'd9; disp_rd = 1; disp_addr = 10'd0;
      @(negedge clk);
      wr_valid = 0; clr_start = 1; clr_data = 4'd2;
      @(negedge clk);
      clr_start = 0;
      @(negedge clk);
      disp_rd = 0;
      tmo = 1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (CLR_BUSY && WR_READY) rdy_hi++;
         if (!CLR_BUSY) begin tmo = 0; break; end
      end
      cyc(3);
      check("pend_timeout", 64'(tmo), 64'd0);
      check("pend_first_write", 64'(wr_log[0]), 64'd50);
      check("pend_clear_start", 64'(wr_log[1]), 64'd0);
      check("pend_write_count", 64'(wr_log.size()), 64'(PIX + 1));
      check("pend_ready_low", 64'(rdy_hi), 64'd0);

      // reset in the middle of a clear
      clr_start = 1; clr_data = 4'd5;
      @(negedge clk);
      clr_start = 0;
      found = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (MEM_WE && MEM_ADDR == 10'd150) begin found = 1; break; end
      end
      check("midclear_reached", 64'(found), 64'd1);
      #1 rst_n = 0;
      #1 check("midclear_reset_outputs", 64'(outs), 64'd0);
      cyc(2);
      rst_n = 1;
      base = we_cnt;
      cyc(20);
      check("post_reset_no_we", 64'(we_cnt - base), 64'd0);
      check("post_reset_busy", 64'(CLR_BUSY), 64'd0);
      check("post_reset_err", 64'(ADDR_ERR), 64'd0);
      check("post_reset_ready", 64'(WR_READY), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
